// File: rtl/two_to_four_decoder_strobe_pkg.sv
// Shared types and constants for the registered 2-to-4 decoder with timed strobe.
package two_to_four_decoder_strobe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // One-hot output lines: [3]=A, [2]=B, [1]=C, [0]=D.
  localparam logic [3:0] ONEHOT_A = 4'b1000;
  localparam logic [3:0] ONEHOT_B = 4'b0100;
  localparam logic [3:0] ONEHOT_C = 4'b0010;
  localparam logic [3:0] ONEHOT_D = 4'b0001;

endpackage

// File: rtl/two_to_four_decoder.sv
// Combinational {E1,E0} -> one-hot {A,B,C,D}; exact inverse of E0=A|B, E1=A|C.
module two_to_four_decoder
  import two_to_four_decoder_strobe_pkg::*;
(
  input  logic [1:0] i_code,
  output logic [3:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    case (i_code)
      2'b11:   o_onehot = ONEHOT_A;
      2'b01:   o_onehot = ONEHOT_B;
      2'b10:   o_onehot = ONEHOT_C;
      default: o_onehot = ONEHOT_D;
    endcase
  end

endmodule

// File: rtl/two_to_four_decoder_strobe.sv
// Registered 2-to-4 decoder: accepts a code by valid/ready, holds the one-hot
// line for HOLD_CYCLES clocks, then enforces GAP_CYCLES of dead time.
module two_to_four_decoder_strobe
  import two_to_four_decoder_strobe_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] code,
  input  logic       abort,
  output logic [3:0] out_abcd,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_out;
  logic             r_busy;
  logic             r_done;

  logic [3:0]       w_onehot;
  logic             w_xfer;

  two_to_four_decoder u_dec (
    .i_code   (code),
    .o_onehot (w_onehot)
  );

  assign in_ready = (r_state == ST_IDLE) && !abort;
  assign w_xfer   = in_valid && in_ready;

  assign out_abcd = r_out;
  assign busy     = r_busy;
  assign done     = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_state <= ST_HOLD;
            r_out   <= w_onehot;
            r_busy  <= 1'b1;
            r_cnt   <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == '0) begin
            r_out  <= '0;
            r_done <= 1'b1;
            // With no gap the block is ready again in the same cycle done pulses.
            if (GAP_CYCLES == 0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_GAP;
              r_cnt   <= GAP_LOAD;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (abort || (r_cnt == '0)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_out   <= '0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_two_to_four_decoder_strobe.sv
// Directed bench for two_to_four_decoder_strobe: default build plus a GAP_CYCLES=0 build.
module tb_two_to_four_decoder_strobe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, abort;
  logic [1:0] code;
  logic       in_ready, busy, done;
  logic [3:0] out_abcd;

  logic       v2, a2;
  logic [1:0] c2;
  logic       rdy2, busy2, done2;
  logic [3:0] out2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  two_to_four_decoder_strobe #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .code(code), .abort(abort), .out_abcd(out_abcd), .busy(busy), .done(done)
  );

  two_to_four_decoder_strobe #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .CNT_W(8)) dut_nogap (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
    .code(c2), .abort(a2), .out_abcd(out2), .busy(busy2), .done(done2)
  );

  typedef struct {
    logic [1:0] code;
    logic [3:0] exp_out;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2'b11, 4'b1000};
    vecs[1] = '{2'b01, 4'b0100};
    vecs[2] = '{2'b10, 4'b0010};
    vecs[3] = '{2'b00, 4'b0001};

    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; code = 2'b00;
    v2 = 1'b0; a2 = 1'b0; c2 = 2'b00;

    // 1. reset
    repeat (3) tick();
    check("rst_out", out_abcd, 4'b0000);
    check("rst_busy", 4'(busy), 4'd0);
    check("rst_done", 4'(done), 4'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 4'(in_ready), 4'd1);
    tick();

    // 2 + 3. valid held high, stepping through the table; code changes during hold are ignored
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      code = vecs[i].code;
      #1;
      check("acc_ready_c0", 4'(in_ready), 4'd1);
      tick();
      if (i < 3) code = vecs[i+1].code;
      else       code = 2'b11;
      for (int k = 1; k <= 4; k++) begin
        check("hold_out", out_abcd, vecs[i].exp_out);
        check("hold_busy", 4'(busy), 4'd1);
        check("hold_ready", 4'(in_ready), 4'd0);
        check("hold_done", 4'(done), 4'd0);
        tick();
      end
      check("gap_out", out_abcd, 4'b0000);
      check("gap_done", 4'(done), 4'd1);
      check("gap_busy", 4'(busy), 4'd1);
      check("gap_ready", 4'(in_ready), 4'd0);
      if (i == 3) in_valid = 1'b0;
      tick();
    end
    check("idle_ready", 4'(in_ready), 4'd1);
    check("idle_done", 4'(done), 4'd0);
    check("idle_busy", 4'(busy), 4'd0);

    // 4. second code during hold is ignored
    in_valid = 1'b1; code = 2'b01;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; code = 2'b10;
    for (int k = 2; k <= 4; k++) begin
      check("ign_out", out_abcd, 4'b0100);
      tick();
    end
    in_valid = 1'b0;
    check("ign_c5_out", out_abcd, 4'b0000);
    tick();
    check("ign_c6_out", out_abcd, 4'b0000);

    // 5. abort in HOLD
    in_valid = 1'b1; code = 2'b00;
    tick();
    in_valid = 1'b0;
    check("ab_c1_out", out_abcd, 4'b0001);
    tick();
    abort = 1'b1;
    #1;
    check("ab_c2_ready", 4'(in_ready), 4'd0);
    tick();
    abort = 1'b0;
    #1;
    check("ab_c3_out", out_abcd, 4'b0000);
    check("ab_c3_busy", 4'(busy), 4'd0);
    check("ab_c3_done", 4'(done), 4'd0);
    check("ab_c3_ready", 4'(in_ready), 4'd1);
    tick();
    check("ab_c4_done", 4'(done), 4'd0);

    // abort in GAP
    in_valid = 1'b1; code = 2'b11;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("abg_c5_done", 4'(done), 4'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abg_c6_busy", 4'(busy), 4'd0);
    check("abg_c6_done", 4'(done), 4'd0);

    // abort with valid in IDLE: nothing accepted
    abort = 1'b1; in_valid = 1'b1; code = 2'b11;
    #1;
    check("abi_ready", 4'(in_ready), 4'd0);
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check("abi_out", out_abcd, 4'b0000);
    check("abi_busy", 4'(busy), 4'd0);

    // 6. async reset mid-hold
    in_valid = 1'b1; code = 2'b10;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("ar_c3_pre", out_abcd, 4'b0010);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_out", out_abcd, 4'b0000);
    check("ar_busy", 4'(busy), 4'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("ar_ready", 4'(in_ready), 4'd1);
    tick();
    check("ar_post_out", out_abcd, 4'b0000);

    // GAP_CYCLES=0 build
    v2 = 1'b1; c2 = 2'b11;
    tick();
    v2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("ng_hold_out", out2, 4'b1000);
      check("ng_hold_ready", 4'(rdy2), 4'd0);
      tick();
    end
    check("ng_c5_out", out2, 4'b0000);
    check("ng_c5_done", 4'(done2), 4'd1);
    check("ng_c5_ready", 4'(rdy2), 4'd1);
    check("ng_c5_busy", 4'(busy2), 4'd0);
    tick();
    check("ng_c6_done", 4'(done2), 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
